convolution_mem_ctrl: RTL
=========================

CONVOLUTION_MEM_CTRL -- requirements
Module: convolution_mem_ctrl

Interface
REQ-001 Parameter DATA_W, default 16: sample and memory word width.
REQ-002 Parameter ADDR_W, default 16: memory address width.
REQ-003 Parameter MAX_TAPS, default 64: maximum impulse taps processed per sample.
REQ-004 Parameter COEF_W, default 8: tap coefficient magnitude width, unsigned Q0.COEF_W.
REQ-005 clk  in  1  single clock for all logic.
REQ-006 rst_n  in  1  asynchronous, active-low reset.
REQ-007 sample_stb  in  1  one-cycle pulse, new ADC sample on sample_in.
REQ-008 sample_in  in  DATA_W  signed ADC sample.
REQ-009 record_en  in  1  write incoming samples into the ring buffer.
REQ-010 loop_en  in  1  freeze buffer contents; replay the recorded loop.
REQ-011 tap_count  in  clog2(MAX_TAPS+1)  active taps; values above MAX_TAPS clamp to MAX_TAPS.
REQ-012 buf_base  in  ADDR_W  first ring address; tap table occupies 0..MAX_TAPS-1.
REQ-013 mem_req / mem_we / mem_addr / mem_wdata  out  1/1/ADDR_W/DATA_W  memory request.
REQ-014 mem_ready  in  1  one-cycle ack; read data valid on mem_rdata (DATA_W, in) in the same cycle.
REQ-015 sample_out  out  DATA_W  signed wet output; out_valid  out  1  one-cycle pulse.
REQ-016 busy  out  1  frame in progress; overrun  out  1  sticky dropped-strobe flag.

Function
REQ-017 The FSM SHALL use states IDLE, WRITE, TAP_RD, SMP_RD, OUTPUT.
REQ-018 IDLE + sample_stb: latch sample_in and buf_base; acc <= sample_in <<< COEF_W (dry path at unity); delay <= 0; tap index <= 0.
REQ-019 From IDLE: go to WRITE if record_en=1 and loop_en=0; else TAP_RD, or OUTPUT if clamped tap_count=0.
REQ-020 WRITE: mem_req=1, mem_we=1, mem_addr=wr_ptr, mem_wdata=latched sample, held until mem_ready.
REQ-021 TAP_RD: read address = tap index. Tap word fields: [15:9] delay increment, [8] sign, [7:0] coefficient. On mem_ready: delay += increment.
REQ-022 Delay saturation: delay SHALL saturate at ring length-1, ring length = 2^ADDR_W - buf_base.
REQ-023 SMP_RD: read wr_ptr - delay; a result below buf_base wraps by adding ring length.
REQ-024 SMP_RD accumulate: on mem_ready, acc += or -= (per sign) mem_rdata*coefficient.
REQ-025 SMP_RD next state: TAP_RD while tap index+1 < tap_count, else OUTPUT.
REQ-026 Accumulator width SHALL be DATA_W+COEF_W+clog2(MAX_TAPS)+1, so no intermediate overflow occurs.
REQ-027 OUTPUT: sample_out <= acc >>> COEF_W saturated to the signed DATA_W range; out_valid pulses one cycle.
REQ-028 OUTPUT: wr_ptr advances, wrapping from 2^ADDR_W-1 to buf_base; next state IDLE.
REQ-029 wr_ptr SHALL advance every frame regardless of record_en/loop_en, so loop_en replays the ring.
REQ-030 A wr_ptr below the latched buf_base SHALL be forced to buf_base at frame start.
REQ-031 mem_req SHALL be 0 in IDLE and OUTPUT; request signals SHALL remain stable until mem_ready.
REQ-032 sample_stb while busy=1 SHALL be dropped and SHALL set overrun; no frame restart.
REQ-033 busy SHALL be 1 in every state except IDLE.

Reset
REQ-034 rst_n low SHALL asynchronously force: state IDLE; wr_ptr = 0 (corrected per REQ-030); acc, delay, tap index = 0.
REQ-035 rst_n low SHALL asynchronously force: mem_req, mem_we, mem_addr, mem_wdata = 0; sample_out = 0; out_valid, busy, overrun = 0.
REQ-036 Reset mid-frame SHALL abandon the frame with no out_valid; an outstanding memory request is dropped.

Structure
REQ-037 Package convolution_mem_pkg SHALL hold: state encoding, tap field positions (DELAY_MSB/LSB, SIGN_BIT, COEF_MSB/LSB), accumulator-width function.
REQ-038 Sub-module tap_mac (signed sample x unsigned coef, sign-conditional add, saturating output) SHALL hold the arithmetic; the FSM stays in the top.

Verification
REQ-039 Check: tap_count=0, record_en=1, sample_in=0x1234 -> one write at buf_base; sample_out=0x1234; out_valid 1 cycle.
REQ-040 Check: one tap (incr=1, sign=0, coef=0x80); samples 0x1000 then 0x2000 -> second sample_out = 0x2000+0x0800 = 0x2800.
REQ-041 Check: buf_base=0xFFF0, 20 frames -> wr_ptr wraps 0xFFFF->0xFFF0; taps with delay > wr_ptr offset read wrapped addresses.
REQ-042 Check saturation: two taps coef=0xFF, sign=0 on 0x7FFF history, dry 0x7FFF -> sample_out=0x7FFF; negative analog -> 0x8000.
REQ-043 Check loop_en=1 for 32 frames -> no mem_we pulses; outputs repeat with ring period.
REQ-044 Check: sample_stb while busy -> overrun=1, frame completes once; then rst_n pulse mid-SMP_RD -> all outputs 0, state IDLE.

Source files
------------

// File: rtl/convolution_mem_pkg.sv
// convolution_mem_pkg: shared state encoding, tap word layout and accumulator sizing
package convolution_mem_pkg;
  typedef enum logic [2:0] {IDLE, WRITE, TAP_RD, SMP_RD, OUTPUT} state_e;
  localparam int DELAY_MSB = 15;
  localparam int DELAY_LSB = 9;
  localparam int SIGN_BIT  = 8;
  localparam int COEF_MSB  = 7;
  localparam int COEF_LSB  = 0;
  function automatic int acc_width(input int data_w, input int coef_w, input int max_taps);
    return data_w + coef_w + $clog2(max_taps) + 1;
  endfunction
endpackage

// File: rtl/tap_mac.sv
// tap_mac: signed sample times unsigned coefficient, sign-selected accumulate, saturated readout
module tap_mac #(
  parameter int DATA_W = 16,
  parameter int COEF_W = 8,
  parameter int ACC_W  = 31
) (
  input  logic signed [ACC_W-1:0]  acc_in,
  input  logic signed [DATA_W-1:0] sample,
  input  logic        [COEF_W-1:0] coef,
  input  logic                     neg,
  output logic signed [ACC_W-1:0]  acc_out,
  output logic signed [DATA_W-1:0] sat_out
);
  logic signed [DATA_W+COEF_W:0] prod;
  logic signed [ACC_W-1:0]       prod_ext;
  logic signed [ACC_W-1:0]       shifted;
  logic                          fits;
  // product is sign-extended to the accumulator width before the add/subtract
  always_comb begin
    prod     = sample * $signed({1'b0, coef});
    prod_ext = {{(ACC_W-DATA_W-COEF_W-1){prod[DATA_W+COEF_W]}}, prod};
    acc_out  = neg ? acc_in - prod_ext : acc_in + prod_ext;
    shifted  = acc_in >>> COEF_W;
    fits     = (&shifted[ACC_W-1:DATA_W-1]) || !(|shifted[ACC_W-1:DATA_W-1]);
    sat_out  = fits ? shifted[DATA_W-1:0] : {shifted[ACC_W-1], {(DATA_W-1){~shifted[ACC_W-1]}}};
  end
endmodule

// File: rtl/convolution_mem_ctrl.sv
// convolution_mem_ctrl: ring-buffer recorder and tap-table convolution over a shared memory port
module convolution_mem_ctrl
  import convolution_mem_pkg::*;
#(
  parameter int DATA_W   = 16,
  parameter int ADDR_W   = 16,
  parameter int MAX_TAPS = 64,
  parameter int COEF_W   = 8,
  localparam int TC_W    = $clog2(MAX_TAPS + 1)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              sample_stb,
  input  logic [DATA_W-1:0] sample_in,
  input  logic              record_en,
  input  logic              loop_en,
  input  logic [TC_W-1:0]   tap_count,
  input  logic [ADDR_W-1:0] buf_base,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_ready,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic [DATA_W-1:0] sample_out,
  output logic              out_valid,
  output logic              busy,
  output logic              overrun
);
  localparam int ACC_W = acc_width(DATA_W, COEF_W, MAX_TAPS);
  state_e                   state_q, state_d;
  logic [ADDR_W-1:0]        wr_ptr_q, wr_ptr_d, base_q, base_d, delay_q, delay_d;
  logic [DATA_W-1:0]        smp_q, smp_d, sample_out_q, sample_out_d;
  logic signed [ACC_W-1:0]  acc_q, acc_d, mac_acc;
  logic signed [DATA_W-1:0] mac_sat;
  logic [TC_W-1:0]          idx_q, idx_d, tc;
  logic [COEF_W-1:0]        coef_q, coef_d;
  logic                     neg_q, neg_d, out_valid_q, out_valid_d, overrun_q, overrun_d;
  logic [ADDR_W:0]          ring_len, delay_max, delay_sum, raw;
  logic [ADDR_W-1:0]        rd_addr, delay_new;
  logic                     below;

  tap_mac #(.DATA_W(DATA_W), .COEF_W(COEF_W), .ACC_W(ACC_W)) u_mac (
    .acc_in  (acc_q),
    .sample  ($signed(mem_rdata)),
    .coef    (coef_q),
    .neg     (neg_q),
    .acc_out (mac_acc),
    .sat_out (mac_sat)
  );

  // ring geometry: saturating delay and wrapped read address below the ring base
  always_comb begin
    tc        = (tap_count > TC_W'(MAX_TAPS)) ? TC_W'(MAX_TAPS) : tap_count;
    ring_len  = {1'b1, {ADDR_W{1'b0}}} - {1'b0, base_q};
    delay_max = ring_len - (ADDR_W+1)'(1);
    delay_sum = {1'b0, delay_q} + (ADDR_W+1)'(mem_rdata[DELAY_MSB:DELAY_LSB]);
    delay_new = (delay_sum > delay_max) ? delay_max[ADDR_W-1:0] : delay_sum[ADDR_W-1:0];
    raw       = {1'b0, wr_ptr_q} - {1'b0, delay_q};
    below     = raw[ADDR_W] || (raw[ADDR_W-1:0] < base_q);
    rd_addr   = below ? raw[ADDR_W-1:0] + ring_len[ADDR_W-1:0] : raw[ADDR_W-1:0];
  end

  // next-state, datapath updates and memory request decode
  always_comb begin
    state_d      = state_q;
    wr_ptr_d     = wr_ptr_q;
    base_d       = base_q;
    delay_d      = delay_q;
    smp_d        = smp_q;
    acc_d        = acc_q;
    idx_d        = idx_q;
    coef_d       = coef_q;
    neg_d        = neg_q;
    sample_out_d = sample_out_q;
    out_valid_d  = 1'b0;
    overrun_d    = overrun_q | (sample_stb & (state_q != IDLE));
    mem_req      = 1'b0;
    mem_we       = 1'b0;
    mem_addr     = '0;
    mem_wdata    = '0;
    case (state_q)
      IDLE: if (sample_stb) begin
        smp_d    = sample_in;
        base_d   = buf_base;
        acc_d    = {{(ACC_W-DATA_W){sample_in[DATA_W-1]}}, sample_in} << COEF_W;
        delay_d  = '0;
        idx_d    = '0;
        wr_ptr_d = (wr_ptr_q < buf_base) ? buf_base : wr_ptr_q;
        state_d  = (record_en && !loop_en) ? WRITE : (tc == '0) ? OUTPUT : TAP_RD;
      end
      WRITE: begin
        mem_req   = 1'b1;
        mem_we    = 1'b1;
        mem_addr  = wr_ptr_q;
        mem_wdata = smp_q;
        if (mem_ready) state_d = (tc == '0) ? OUTPUT : TAP_RD;
      end
      TAP_RD: begin
        mem_req  = 1'b1;
        mem_addr = ADDR_W'(idx_q);
        if (mem_ready) begin
          delay_d = delay_new;
          neg_d   = mem_rdata[SIGN_BIT];
          coef_d  = COEF_W'(mem_rdata[COEF_MSB:COEF_LSB]);
          state_d = SMP_RD;
        end
      end
      SMP_RD: begin
        mem_req  = 1'b1;
        mem_addr = rd_addr;
        if (mem_ready) begin
          acc_d   = mac_acc;
          idx_d   = idx_q + TC_W'(1);
          state_d = ({1'b0, idx_q} + (TC_W+1)'(1) < {1'b0, tc}) ? TAP_RD : OUTPUT;
        end
      end
      OUTPUT: begin
        sample_out_d = mac_sat;
        out_valid_d  = 1'b1;
        wr_ptr_d     = (&wr_ptr_q) ? base_q : wr_ptr_q + ADDR_W'(1);
        state_d      = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // state and datapath registers, cleared asynchronously
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      wr_ptr_q     <= '0;
      base_q       <= '0;
      delay_q      <= '0;
      smp_q        <= '0;
      acc_q        <= '0;
      idx_q        <= '0;
      coef_q       <= '0;
      neg_q        <= 1'b0;
      sample_out_q <= '0;
      out_valid_q  <= 1'b0;
      overrun_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      wr_ptr_q     <= wr_ptr_d;
      base_q       <= base_d;
      delay_q      <= delay_d;
      smp_q        <= smp_d;
      acc_q        <= acc_d;
      idx_q        <= idx_d;
      coef_q       <= coef_d;
      neg_q        <= neg_d;
      sample_out_q <= sample_out_d;
      out_valid_q  <= out_valid_d;
      overrun_q    <= overrun_d;
    end
  end

  assign sample_out = sample_out_q;
  assign out_valid  = out_valid_q;
  assign overrun    = overrun_q;
  assign busy       = (state_q != IDLE);
endmodule
